// File: rtl/tempo_scheduler_if.sv
// Control/status bundle between round judging, tempo_scheduler and clock_divider.
// Round pulses flow master->slave; divider programming and game status flow back.
interface tempo_scheduler_if #(
  parameter int FREQ_W = 27
);
  logic              start;
  logic              round_pass;
  logic              round_fail;
  logic [FREQ_W-1:0] freq;
  logic              div_reset;
  logic [3:0]        level;
  logic [1:0]        lives;
  logic              game_over;

  modport master (
    output start,
    output round_pass,
    output round_fail,
    input  freq,
    input  div_reset,
    input  level,
    input  lives,
    input  game_over
  );

  modport slave (
    input  start,
    input  round_pass,
    input  round_fail,
    output freq,
    output div_reset,
    output level,
    output lives,
    output game_over
  );
endinterface

// File: rtl/tempo_scheduler.sv
// Game tempo sequencer: programs clock_divider freq and holds/releases its reset.
// Optional macro TEMPO_LIVES_EN enables a lives counter (retry on fail).
module tempo_scheduler #(
  parameter int FREQ_W    = 27,
  parameter int FREQ_INIT = 10,
  parameter int FREQ_STEP = 2,
  parameter int FREQ_MIN  = 5,
  parameter int MAX_LEVEL = 15,
  parameter int NUM_LIVES = 3
) (
  input  logic        clk,
  input  logic        reset,
  tempo_scheduler_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] UPDATE = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] OVER   = 2'd3;

`ifdef TEMPO_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  localparam logic [FREQ_W-1:0] F_INIT  = FREQ_W'(FREQ_INIT);
  localparam logic [FREQ_W-1:0] F_MIN   = FREQ_W'(FREQ_MIN);
  localparam logic [FREQ_W-1:0] F_STEP  = FREQ_W'(FREQ_STEP);
  localparam logic [FREQ_W-1:0] F_FLOOR = FREQ_W'(FREQ_MIN + FREQ_STEP);
  localparam logic [3:0]        L_MAX   = 4'(MAX_LEVEL);
  localparam logic [1:0]        L_START = LIVES_EN ? 2'(NUM_LIVES) : 2'd0;

  logic [1:0]        state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [3:0]        level_q, level_d;
  logic [1:0]        lives_q, lives_d;
  logic              div_reset_q, div_reset_d;
  logic              game_over_q, game_over_d;

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    level_d = level_q;
    lives_d = lives_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d = UPDATE;
          freq_d  = F_INIT;
          level_d = '0;
          lives_d = L_START;
        end
      end
      UPDATE: state_d = RUN;
      RUN: begin
        // fail has priority; a coincident pass is dropped
        if (bus.round_fail) begin
          if (LIVES_EN && lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = UPDATE;
          end else begin
            lives_d = '0;
            state_d = OVER;
          end
        end else if (bus.round_pass) begin
          state_d = UPDATE;
          freq_d  = (freq_q < F_FLOOR) ? F_MIN
                                       : freq_q - F_STEP;
          level_d = (level_q >= L_MAX) ? L_MAX
                                       : level_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    div_reset_d = (state_d != RUN);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      freq_q      <= F_INIT;
      level_q     <= '0;
      lives_q     <= '0;
      div_reset_q <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      div_reset_q <= div_reset_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.freq      = freq_q;
  assign bus.div_reset = div_reset_q;
  assign bus.level     = level_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_tempo_scheduler.sv
// Scoreboard bench for tempo_scheduler with hand-computed directed vectors.
// Stimulus queues the expected post-edge outputs; a monitor pops and compares.
module tb_tempo_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

`ifdef TEMPO_LIVES_EN
  localparam int L0 = 3;
`else
  localparam int L0 = 0;
`endif

  typedef struct {
    int          due;
    logic [26:0] freq;
    logic        dr;
    logic [3:0]  lvl;
    logic [1:0]  lives;
    logic        go;
    string       name;
  } exp_t;

  exp_t q[$];

  tempo_scheduler_if #(.FREQ_W(27)) bus();

  tempo_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (bus.freq !== e.freq || bus.div_reset !== e.dr ||
          bus.level !== e.lvl || bus.lives !== e.lives ||
          bus.game_over !== e.go) begin
        n_fail++;
        $display("FAIL %s @%0d: got f=%0d dr=%0b l=%0d lv=%0d go=%0b exp f=%0d dr=%0b l=%0d lv=%0d go=%0b",
          e.name, cyc, bus.freq, bus.div_reset, bus.level,
          bus.lives, bus.game_over, e.freq, e.dr, e.lvl,
          e.lives, e.go);
      end
    end
  end

  task automatic step(
    input logic r, input logic s,
    input logic p, input logic f,
    input int ef, input logic edr, input int el,
    input int elv, input logic ego, input string nm
  );
    exp_t e;
    reset          = r;
    bus.start      = s;
    bus.round_pass = p;
    bus.round_fail = f;
    e.due   = cyc + 1;
    e.freq  = 27'(ef);
    e.dr    = edr;
    e.lvl   = 4'(el);
    e.lives = 2'(elv);
    e.go    = ego;
    e.name  = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ef;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.round_pass = 1'b0;
    bus.round_fail = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 10, 1, 0, 0, 0, "reset");

    step(0, 0, 1, 1, 10, 1, 0, 0, 0, "idle_ignore");
    step(0, 1, 0, 0, 10, 1, 0, L0, 0, "start_upd");
    step(0, 0, 0, 0, 10, 0, 0, L0, 0, "run0");
    step(0, 0, 0, 0, 10, 0, 0, L0, 0, "run1");

    step(0, 0, 1, 0, 8, 1, 1, L0, 0, "pass1");
    step(0, 0, 0, 0, 8, 0, 1, L0, 0, "run_p1");
    step(0, 0, 0, 0, 8, 0, 1, L0, 0, "hold_p1");
    step(0, 0, 0, 0, 8, 0, 1, L0, 0, "hold_p1");
    step(0, 0, 1, 0, 6, 1, 2, L0, 0, "pass2");
    step(0, 0, 0, 0, 6, 0, 2, L0, 0, "run_p2");
    step(0, 0, 0, 0, 6, 0, 2, L0, 0, "hold_p2");
    step(0, 0, 0, 0, 6, 0, 2, L0, 0, "hold_p2");
    step(0, 0, 1, 0, 5, 1, 3, L0, 0, "pass3_floor");
    step(0, 0, 0, 0, 5, 0, 3, L0, 0, "run_p3");
    step(0, 0, 1, 0, 5, 1, 4, L0, 0, "pass_at_min");
    step(0, 0, 0, 0, 5, 0, 4, L0, 0, "run_p4");
    step(0, 1, 0, 0, 5, 0, 4, L0, 0, "start_in_run");

`ifdef TEMPO_LIVES_EN
    step(0, 0, 0, 1, 5, 1, 4, 2, 0, "fail_l2");
    step(0, 0, 0, 0, 5, 0, 4, 2, 0, "retry_l2");
    step(0, 0, 1, 1, 5, 1, 4, 1, 0, "fail_l1");
    step(0, 0, 0, 0, 5, 0, 4, 1, 0, "retry_l1");
    step(0, 0, 0, 1, 5, 1, 4, 0, 1, "fail_over");
`else
    step(0, 0, 1, 1, 5, 1, 4, 0, 1, "pass_fail_over");
`endif
    step(0, 0, 0, 0, 5, 1, 4, 0, 1, "over_hold");
    step(0, 0, 1, 0, 5, 1, 4, 0, 1, "over_pass_ign");

    step(0, 1, 0, 0, 10, 1, 0, L0, 0, "restart_upd");
    step(0, 0, 0, 0, 10, 0, 0, L0, 0, "restart_run");

    step(0, 0, 1, 0, 8, 1, 1, L0, 0, "pass_pre_rst");
    step(1, 0, 0, 0, 10, 1, 0, 0, 0, "rst_in_update");
    step(0, 0, 1, 0, 10, 1, 0, 0, 0, "idle_after_rst");

    step(0, 1, 0, 0, 10, 1, 0, L0, 0, "sat_start");
    step(0, 0, 0, 0, 10, 0, 0, L0, 0, "sat_run");
    for (int i = 1; i <= 17; i++) begin
      ef = (i == 1) ? 8 : (i == 2) ? 6 : 5;
      step(0, 0, 1, 0, ef, 1, (i > 15) ? 15 : i, L0, 0,
           "sat_pass");
      step(0, 0, 0, 0, ef, 0, (i > 15) ? 15 : i, L0, 0,
           "sat_run");
    end

`ifndef TEMPO_LIVES_EN
    step(0, 0, 0, 1, 5, 1, 15, 0, 1, "fail_over");
    step(0, 0, 0, 0, 5, 1, 15, 0, 1, "over_hold2");
`endif

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
